// File: rtl/test_mixer_core.sv
// Pattern engine for the user area: a synchronized enable starts either a
// thermometer fill or a saturating count on a 5-bit pad bus, ending at 5'b11111.
module test_mixer_core #(
   parameter int unsigned DIV = 4
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic       i_enable,
   input  logic       i_test,
   output logic [4:0] o_result,
   output logic [2:0] o_oeb,
   output logic       o_done
);

   localparam logic [7:0] LastCount = 8'(DIV - 1);
   localparam logic [4:0] AllOnes   = 5'b11111;

   logic       enMeta_q, enSync_q, enPrev_q;
   logic       testMeta_q, testSync_q;
   logic       mode_q, mode_d;
   logic [7:0] presc_q, presc_d;
   logic [4:0] result_q, result_d;
   logic       start, tick, activeMode;
   logic [4:0] base;

   // Pads are asynchronous to clock, so both pass through two-flop synchronizers.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         enMeta_q   <= 1'b0;
         enSync_q   <= 1'b0;
         enPrev_q   <= 1'b0;
         testMeta_q <= 1'b0;
         testSync_q <= 1'b0;
         mode_q     <= 1'b0;
         presc_q    <= 8'd0;
         result_q   <= 5'd0;
      end else begin
         enMeta_q   <= i_enable;
         enSync_q   <= enMeta_q;
         enPrev_q   <= enSync_q;
         testMeta_q <= i_test;
         testSync_q <= testMeta_q;
         mode_q     <= mode_d;
         presc_q    <= presc_d;
         result_q   <= result_d;
      end
   end

   // The prescaler already sits at 0 on the start cycle, so a tick may land there
   // (DIV = 1); that tick must use the mode being sampled in the same cycle.
   always_comb begin
      start      = enSync_q & ~enPrev_q;
      activeMode = start ? testSync_q : mode_q;
      tick       = enSync_q && (presc_q == LastCount);
      base       = start ? 5'd0 : result_q;
      mode_d     = activeMode;
      presc_d    = presc_q;
      result_d   = result_q;
      if (!enSync_q) begin
         presc_d  = 8'd0;
         result_d = 5'd0;
      end else begin
         presc_d  = tick ? 8'd0 : presc_q + 8'd1;
         result_d = base;
         if (tick && base != AllOnes) begin
            result_d = activeMode ? {base[3:0], 1'b1} : base + 5'd1;
         end
      end
   end

   assign o_result = result_q;
   assign o_done   = enSync_q && (result_q == AllOnes);
   assign o_oeb    = 3'b110;

endmodule

// File: tb/tb_test_mixer_core.sv
// Self-checking bench for test_mixer_core: directed phases plus random enable/mode
// activity, compared each cycle against a cycles-since-start reference model.
module tb_test_mixer_core;

   localparam int unsigned DIV = 4;

   logic       clock = 1'b0;
   logic       resetb;
   logic       i_enable;
   logic       i_test;
   logic [4:0] o_result;
   logic [2:0] o_oeb;
   logic       o_done;

   int testCount = 0;
   int failCount = 0;

   test_mixer_core #(.DIV(DIV)) dut (
      .clock    (clock),
      .resetb   (resetb),
      .i_enable (i_enable),
      .i_test   (i_test),
      .o_result (o_result),
      .o_oeb    (o_oeb),
      .o_done   (o_done)
   );

   always #5 clock = ~clock;

   // Reference: pads delayed two edges, then the output is a pure function of
   // how many cycles have elapsed since the start cycle and the latched mode.
   logic mEnMeta, mEnS, mEnPrev, mTestMeta, mTestS, mRun, mMode;
   int   mK;

   always @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         mEnMeta <= 0; mEnS <= 0; mEnPrev <= 0;
         mTestMeta <= 0; mTestS <= 0;
         mRun <= 0; mMode <= 0; mK <= 0;
      end else begin
         mEnMeta   <= i_enable;
         mEnS      <= mEnMeta;
         mEnPrev   <= mEnS;
         mTestMeta <= i_test;
         mTestS    <= mTestMeta;
         if (mEnS && !mEnPrev) begin
            mRun <= 1; mMode <= mTestS; mK <= 1;
         end else if (mEnS) begin
            if (mK < 100000) mK <= mK + 1;
         end else begin
            mRun <= 0; mK <= 0;
         end
      end
   end

   function automatic logic [4:0] patternAt(input logic fill, input int k);
      int n;
      n = k / int'(DIV);
      if (fill) return (n >= 5) ? 5'd31 : 5'((1 << n) - 1);
      return (n >= 31) ? 5'd31 : 5'(n);
   endfunction

   logic [4:0] expResult;
   logic       expDone;
   always_comb begin
      expResult = mRun ? patternAt(mMode, mK) : 5'd0;
      expDone   = mEnS && (expResult == 5'd31);
   end

   task automatic checkOutput(input string tag);
      testCount++;
      assert (o_result === expResult) else begin
         failCount++;
         $error("[TB] FAIL %s result: observed %b expected %b", tag, o_result, expResult);
      end
      testCount++;
      assert (o_done === expDone) else begin
         failCount++;
         $error("[TB] FAIL %s done: observed %b expected %b", tag, o_done, expDone);
      end
      testCount++;
      assert (o_oeb === 3'b110) else begin
         failCount++;
         $error("[TB] FAIL %s oeb: observed %b expected 110", tag, o_oeb);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic test);
      i_enable = en;
      i_test   = test;
   endtask

   task automatic runCycle(input string tag);
      @(negedge clock);
      checkOutput(tag);
   endtask

   task automatic waitForResult(input logic [4:0] target, input int limit, input string tag);
      bit found;
      found = 0;
      for (int i = 0; i < limit && !found; i++) begin
         runCycle(tag);
         if (o_result === target && expResult == target) found = 1;
      end
      testCount++;
      assert (found) else begin
         failCount++;
         $error("[TB] FAIL %s reach: observed %b expected %b within %0d cycles", tag, o_result, target, limit);
      end
   endtask

   initial begin
      resetb = 1'b0;
      applyStimulus(1, 0);
      repeat (4) runCycle("reset");
      resetb = 1'b1;
      repeat (12) runCycle("relStart");
      applyStimulus(0, 1);
      repeat (6) runCycle("idle");

      applyStimulus(1, 1);
      waitForResult(5'b11111, 40, "fillTop");
      repeat (55) runCycle("fillHold");
      applyStimulus(0, 0);
      repeat (6) runCycle("stop");

      applyStimulus(1, 0);
      repeat (12) runCycle("count");
      applyStimulus(1, 1);
      waitForResult(5'b11111, 150, "countTop");
      repeat (20) runCycle("countHold");

      applyStimulus(0, 1);
      repeat (5) runCycle("gap");
      applyStimulus(1, 1);
      waitForResult(5'b00111, 40, "fill7");
      applyStimulus(0, 1);
      repeat (3) runCycle("drop");
      testCount++;
      assert (o_result === 5'd0) else begin
         failCount++;
         $error("[TB] FAIL dropZero: observed %b expected 00000", o_result);
      end
      applyStimulus(1, 1);
      waitForResult(5'b00001, 20, "restart1");
      waitForResult(5'b01111, 30, "fill15");

      #3 resetb = 1'b0;
      #1 checkOutput("asyncClr");
      repeat (3) runCycle("inReset");
      resetb = 1'b1;
      waitForResult(5'b11111, 60, "afterRst");

      for (int it = 0; it < 25; it++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(1, 40)) runCycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
